// File: rtl/qspi_mem_responder_pkg.sv
// Shared types and constants for the QSPI memory responder.
// Optional error counter in the top is enabled by defining QSPI_RESP_ERRCNT_EN.
package qspi_resp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RDATA,
        WDATA,
        IGNORE
    } state_t;

    localparam logic [7:0]  CMD_READ_DEF  = 8'hEB;
    localparam logic [7:0]  CMD_WRITE_DEF = 8'h38;
    localparam int unsigned ADDR_NIBBLES  = 6;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/qspi_mem_responder_ram.sv
// Single-port byte RAM with synchronous read (1 clk latency) so the flow maps it to block RAM.
// Contents are intentionally not reset.
module qspi_resp_ram #(
    parameter int unsigned AWIDTH = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [0:(1 << AWIDTH) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/qspi_mem_responder.sv
// QSPI PSRAM emulator: decodes CPU-driven quad read/write transactions into an on-chip RAM.
// Define QSPI_RESP_ERRCNT_EN to add the err_count output (unknown opcodes and aborted headers).
module qspi_mem_responder
    import qspi_resp_pkg::*;
#(
    parameter int unsigned MEM_AWIDTH   = 12,
    parameter int unsigned DUMMY_CYCLES = 6,
    parameter logic [7:0]  CMD_READ     = CMD_READ_DEF,
    parameter logic [7:0]  CMD_WRITE    = CMD_WRITE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_cs_n,
    input  logic       spi_sck,
    input  logic [3:0] spi_d_in,
    output logic [3:0] spi_d_out,
    output logic       spi_d_oe,
    output logic       busy
`ifdef QSPI_RESP_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [7:0]            ADDR_LAST  = 8'(ADDR_NIBBLES - 1);
    localparam logic [7:0]            DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
    localparam logic [MEM_AWIDTH-1:0] ADDR_ONE   = MEM_AWIDTH'(1);

    logic       cs_s1, cs_s2;
    logic       sck_s1, sck_s2, sck_s3;
    logic [3:0] d_s1, d_s2;

    state_t state, state_nxt;

    logic [7:0]            cnt;
    logic [3:0]            cmd_hi;
    logic                  is_read;
    logic [MEM_AWIDTH-1:0] addr;
    logic                  nib_lo;
    logic [3:0]            wr_hi;
    logic                  rd_req, rd_vld;
    logic [7:0]            rd_byte;

    logic                  sck_rise, sck_fall, cs_abort;
    logic [7:0]            opcode;
    logic                  ram_we;
    logic [7:0]            ram_wdata, ram_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_s1  <= 1'b1;
            cs_s2  <= 1'b1;
            sck_s1 <= 1'b0;
            sck_s2 <= 1'b0;
            sck_s3 <= 1'b0;
            d_s1   <= '0;
            d_s2   <= '0;
        end else begin
            cs_s1  <= spi_cs_n;
            cs_s2  <= cs_s1;
            sck_s1 <= spi_sck;
            sck_s2 <= sck_s1;
            sck_s3 <= sck_s2;
            d_s1   <= spi_d_in;
            d_s2   <= d_s1;
        end
    end

    // SCK edges are masked by synced CS so a coincident CS rise always wins.
    always_comb begin
        sck_rise = sck_s2 & ~sck_s3 & ~cs_s2;
        sck_fall = ~sck_s2 & sck_s3 & ~cs_s2;
        cs_abort = cs_s2 & (state != IDLE);
        opcode   = {cmd_hi, d_s2};
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (cs_abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!cs_s2) state_nxt = CMD;
                end
                CMD: begin
                    if (sck_rise && cnt == 8'd1) begin
                        if (opcode == CMD_READ || opcode == CMD_WRITE) state_nxt = ADDR;
                        else                                           state_nxt = IGNORE;
                    end
                end
                ADDR: begin
                    if (sck_rise && cnt == ADDR_LAST) state_nxt = is_read ? DUMMY : WDATA;
                end
                DUMMY: begin
                    if (sck_rise && cnt == DUMMY_LAST) state_nxt = RDATA;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ram_we    = rst_n && (state == WDATA) && sck_rise && nib_lo;
        ram_wdata = {wr_hi, d_s2};
    end

    // Address shifts within MEM_AWIDTH bits; after six nibbles it holds the low bits of the bus address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            cmd_hi    <= '0;
            is_read   <= 1'b0;
            addr      <= '0;
            nib_lo    <= 1'b0;
            wr_hi     <= '0;
            rd_req    <= 1'b0;
            rd_vld    <= 1'b0;
            rd_byte   <= '0;
            spi_d_out <= '0;
            spi_d_oe  <= 1'b0;
        end else begin
            rd_req <= 1'b0;
            rd_vld <= rd_req;
            if (rd_vld) rd_byte <= ram_rdata;

            if (sck_rise) cnt <= cnt + 8'd1;
            if (state_nxt != state) begin
                cnt    <= '0;
                nib_lo <= 1'b0;
            end

            case (state)
                CMD: begin
                    if (sck_rise) begin
                        cmd_hi  <= d_s2;
                        is_read <= (opcode == CMD_READ);
                    end
                end
                ADDR: begin
                    if (sck_rise) addr <= {addr[MEM_AWIDTH-5:0], d_s2};
                end
                DUMMY: begin
                    if (sck_rise && cnt == 8'd0) rd_req <= 1'b1;
                end
                RDATA: begin
                    if (sck_fall) begin
                        spi_d_oe <= 1'b1;
                        if (!nib_lo) begin
                            spi_d_out <= rd_byte[7:4];
                            nib_lo    <= 1'b1;
                        end else begin
                            spi_d_out <= rd_byte[3:0];
                            nib_lo    <= 1'b0;
                            addr      <= addr + ADDR_ONE;
                            rd_req    <= 1'b1;
                        end
                    end
                end
                WDATA: begin
                    if (sck_rise) begin
                        if (!nib_lo) begin
                            wr_hi  <= d_s2;
                            nib_lo <= 1'b1;
                        end else begin
                            nib_lo <= 1'b0;
                            addr   <= addr + ADDR_ONE;
                        end
                    end
                end
                default: ;
            endcase

            if (state_nxt != RDATA) spi_d_oe <= 1'b0;
        end
    end

`ifdef QSPI_RESP_ERRCNT_EN
    logic err_inc;

    always_comb begin
        err_inc = (cs_abort && (state == CMD || state == ADDR || state == DUMMY))
               || (state == CMD && state_nxt == IGNORE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_inc) begin
            err_count <= sat_inc8(err_count);
        end
    end
`endif

    qspi_resp_ram #(
        .AWIDTH(MEM_AWIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Directed + randomized bench for qspi_mem_responder; memory contents predicted by a byte-array model.
// Checks err_count as well when QSPI_RESP_ERRCNT_EN is defined.
module tb_qspi_mem_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_sck = 1'b0;
    logic [3:0] spi_d_in = '0;
    logic [3:0] spi_d_out;
    logic       spi_d_oe;
    logic       busy;
`ifdef QSPI_RESP_ERRCNT_EN
    logic [7:0] err_count;
`endif

    qspi_mem_responder #(
        .MEM_AWIDTH  (12),
        .DUMMY_CYCLES(6),
        .CMD_READ    (8'hEB),
        .CMD_WRITE   (8'h38)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_cs_n (spi_cs_n),
        .spi_sck  (spi_sck),
        .spi_d_in (spi_d_in),
        .spi_d_out(spi_d_out),
        .spi_d_oe (spi_d_oe),
        .busy     (busy)
`ifdef QSPI_RESP_ERRCNT_EN
        ,
        .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         exp_err = 0;
    logic [7:0] model [4096];
    logic [3:0] got_q [$];
    logic [7:0] rd_bytes [$];
    logic [7:0] wr_q [$];
    bit         oe_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One SCK period (12 clk): sample lanes just before the rise, then rise and fall.
    task automatic pulse(input logic [3:0] nib, input bit expect_oe);
        spi_d_in = nib;
        repeat (6) @(negedge clk);
        if (spi_d_oe !== expect_oe) oe_bad = 1'b1;
        got_q.push_back(spi_d_out);
        spi_sck = 1'b1;
        repeat (6) @(negedge clk);
        spi_sck = 1'b0;
    endtask

    task automatic start_cs();
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic end_cs();
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
        pulse(cmd[7:4], 1'b0);
        pulse(cmd[3:0], 1'b0);
        for (int i = 0; i < 6; i++) pulse(a[23 - 4 * i -: 4], 1'b0);
    endtask

    task automatic do_write(input logic [23:0] a);
        start_cs();
        send_hdr(8'h38, a);
        for (int k = 0; k < wr_q.size(); k++) begin
            pulse(wr_q[k][7:4], 1'b0);
            pulse(wr_q[k][3:0], 1'b0);
            model[(int'(a) + k) % 4096] = wr_q[k];
        end
        end_cs();
    endtask

    task automatic read_hdr(input logic [23:0] a);
        oe_bad = 1'b0;
        start_cs();
        send_hdr(8'hEB, a);
        for (int i = 0; i < 6; i++) pulse(4'h0, 1'b0);
        got_q.delete();
    endtask

    task automatic do_read(input logic [23:0] a, input int n);
        read_hdr(a);
        for (int i = 0; i < 2 * n; i++) pulse(4'h0, 1'b1);
        end_cs();
        rd_bytes.delete();
        for (int k = 0; k < n; k++) rd_bytes.push_back({got_q[2 * k], got_q[2 * k + 1]});
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) model[i] = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_d_out", 32'(spi_d_out), 32'h0);
        chk("rst_oe", 32'(spi_d_oe), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
`ifdef QSPI_RESP_ERRCNT_EN
        chk("rst_err", 32'(err_count), 32'h0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        wr_q = {8'hA5, 8'h3C};
        do_write(24'h000010);
        do_read(24'h000010, 2);
        chk("wr_rd_n0", 32'(got_q[0]), 32'hA);
        chk("wr_rd_n1", 32'(got_q[1]), 32'h5);
        chk("wr_rd_n2", 32'(got_q[2]), 32'h3);
        chk("wr_rd_n3", 32'(got_q[3]), 32'hC);
        chk("wr_rd_oe_window", 32'(oe_bad), 32'h0);

        wr_q = {8'h11};
        do_write(24'h000FFF);
        wr_q = {8'h22};
        do_write(24'h000000);
        do_read(24'h5A0FFF, 2);
        chk("wrap_b0", 32'(rd_bytes[0]), 32'h11);
        chk("wrap_b1", 32'(rd_bytes[1]), 32'h22);
        chk("wrap_oe_window", 32'(oe_bad), 32'h0);

        oe_bad = 1'b0;
        start_cs();
        pulse(4'h9, 1'b0);
        pulse(4'hF, 1'b0);
        for (int i = 0; i < 6; i++) pulse(4'hF, 1'b0);
        chk("ign_busy", 32'(busy), 32'h1);
        chk("ign_no_oe", 32'(oe_bad), 32'h0);
        end_cs();
        exp_err++;
        chk("ign_idle", 32'(busy), 32'h0);
`ifdef QSPI_RESP_ERRCNT_EN
        chk("ign_err", 32'(err_count), 32'(exp_err));
`endif
        do_read(24'h000010, 2);
        chk("ign_ram_b0", 32'(rd_bytes[0]), 32'hA5);
        chk("ign_ram_b1", 32'(rd_bytes[1]), 32'h3C);

        start_cs();
        pulse(4'hE, 1'b0);
        pulse(4'hB, 1'b0);
        for (int i = 0; i < 3; i++) pulse(4'h0, 1'b0);
        spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_idle", 32'(busy), 32'h0);
        repeat (5) @(negedge clk);
        exp_err++;
`ifdef QSPI_RESP_ERRCNT_EN
        chk("abort_err", 32'(err_count), 32'(exp_err));
`endif
        do_read(24'h000010, 1);
        chk("abort_rd", 32'(rd_bytes[0]), 32'hA5);

        wr_q = {8'h77};
        do_write(24'h000020);
        start_cs();
        send_hdr(8'h38, 24'h000020);
        pulse(4'h1, 1'b0);
        end_cs();
        do_read(24'h000020, 1);
        chk("partial_wr", 32'(rd_bytes[0]), 32'h77);
`ifdef QSPI_RESP_ERRCNT_EN
        chk("partial_err", 32'(err_count), 32'(exp_err));
`endif

        read_hdr(24'h000010);
        pulse(4'h0, 1'b1);
        spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("cs_rdata_oe", 32'(spi_d_oe), 32'h0);
        chk("cs_rdata_busy", 32'(busy), 32'h0);
        chk("cs_rdata_oe_on", 32'(oe_bad), 32'h0);
        repeat (5) @(negedge clk);

        read_hdr(24'h000010);
        pulse(4'h0, 1'b1);
        pulse(4'h0, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_rdata_oe", 32'(spi_d_oe), 32'h0);
        chk("rst_rdata_busy", 32'(busy), 32'h0);
        rst_n    = 1'b1;
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        exp_err = 0;
`ifdef QSPI_RESP_ERRCNT_EN
        chk("rst_rdata_err", 32'(err_count), 32'(exp_err));
`endif
        do_read(24'h000010, 1);
        chk("rst_rdata_rd", 32'(rd_bytes[0]), 32'hA5);

        for (int it = 0; it < 6; it++) begin
            logic [23:0] a;
            int          n;
            a = 24'($urandom);
            n = int'($urandom_range(1, 4));
            wr_q.delete();
            for (int k = 0; k < n; k++) wr_q.push_back(8'($urandom));
            do_write(a);
            do_read(a, n);
            for (int k = 0; k < n; k++)
                chk($sformatf("rand%0d_b%0d", it, k), 32'(rd_bytes[k]), 32'(model[(int'(a) + k) % 4096]));
            chk($sformatf("rand%0d_oe", it), 32'(oe_bad), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
